// File: rtl/mmio_port_responder.sv
// MMIO responder beside DataMemory: registered PortOut with valid/ack, synchronized PortIn.
// Optional register-3 free-running cycle counter enabled by defining MMIO_PORT_TIMER_EN.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        OutValid,
   input  logic        OutAck
);

   logic [31:0] r_port_out;
   logic        r_out_valid;
   logic        r_in_changed;
   logic        r_overrun;
   logic [7:0]  r_sync [SYNC_STAGES];
   logic [7:0]  r_prev;

   logic        w_hit;
   logic [1:0]  w_idx;
   logic [7:0]  w_sync_in;
   logic        w_in_edge;
   logic        w_wr_out;
   logic        w_wr_stat;
   logic        w_wr_tmr;
   logic        w_rd_in;
   logic [31:0] w_timer;
   logic [1:0]  w_unused_addr_lsb;

   assign w_hit             = (Address[31:4] == BASE_ADDR[31:4]);
   assign w_idx             = Address[3:2];
   assign w_unused_addr_lsb = Address[1:0];
   assign w_sync_in         = r_sync[SYNC_STAGES-1];
   assign w_in_edge         = (w_sync_in != r_prev);

   assign w_wr_out  = MemWrite && w_hit && (w_idx == 2'd0);
   assign w_wr_stat = MemWrite && w_hit && (w_idx == 2'd2);
   assign w_wr_tmr  = MemWrite && w_hit && (w_idx == 2'd3);
   assign w_rd_in   = MemRead  && w_hit && (w_idx == 2'd1);

   assign Hit      = w_hit;
   assign PortOut  = r_port_out;
   assign OutValid = r_out_valid;

   // PortIn synchronizer plus the prev_in flop used for change detection
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= PortIn;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_sync_in;
      end
   end

   // A store landing together with OutAck keeps the value pending and is not an overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         r_port_out  <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_wr_out) begin
            r_port_out  <= WriteData;
            r_out_valid <= 1'b1;
            if (r_out_valid && !OutAck) r_overrun <= 1'b1;
         end else begin
            if (OutAck) r_out_valid <= 1'b0;
            if (w_wr_stat && WriteData[2]) r_overrun <= 1'b0;
         end
      end
   end

   // New change detection wins over a clearing load or W1C in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_changed <= 1'b0;
      end else if (w_in_edge) begin
         r_in_changed <= 1'b1;
      end else if (w_rd_in || (w_wr_stat && WriteData[0])) begin
         r_in_changed <= 1'b0;
      end
   end

`ifdef MMIO_PORT_TIMER_EN
   logic [31:0] r_timer;

   always_ff @(posedge clk) begin
      if (reset)         r_timer <= '0;
      else if (w_wr_tmr) r_timer <= WriteData;
      else               r_timer <= r_timer + 32'd1;
   end

   assign w_timer = r_timer;
`else
   logic w_unused_tmr;

   assign w_unused_tmr = w_wr_tmr;
   assign w_timer      = '0;
`endif

   always_comb begin
      ReadData = '0;
      if (w_hit) begin
         case (w_idx)
            2'd0:    ReadData = r_port_out;
            2'd1:    ReadData = {24'b0, w_sync_in};
            2'd2:    ReadData = {29'b0, r_overrun, r_out_valid, r_in_changed};
            default: ReadData = w_timer;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed plus randomized bench for mmio_port_responder against a cycle-level register model.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int unsigned S    = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Address = '0;
   logic [31:0] WriteData = '0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn = '0;
   logic [31:0] PortOut;
   logic        OutValid;
   logic        OutAck = 1'b0;

   mmio_port_responder #(.BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
      .PortIn(PortIn), .PortOut(PortOut), .OutValid(OutValid), .OutAck(OutAck)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: architectural register state plus history of sampled PortIn values
   logic [31:0] m_out, m_timer;
   logic        m_valid, m_inchg, m_ovr;
   logic [7:0]  hist [S+1];
   logic [7:0]  pin_v = '0;
   logic [31:0] rd_obs;
   logic        hit_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (a[31:4] == BASE[31:4]) begin
         case (a[3:2])
            2'd0: r = m_out;
            2'd1: r = {24'b0, hist[S-1]};
            2'd2: r = {29'b0, m_ovr, m_valid, m_inchg};
`ifdef MMIO_PORT_TIMER_EN
            default: r = m_timer;
`else
            default: r = '0;
`endif
         endcase
      end
      return r;
   endfunction

   task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic mw, input logic mr, input logic ack);
      logic hit, wr_out, wr_stat, wr_tmr, rd_in, chg;
      @(negedge clk);
      reset = rst; Address = a; WriteData = wd; MemWrite = mw; MemRead = mr;
      OutAck = ack; PortIn = pin_v;
      #1;
      rd_obs  = ReadData;
      hit_obs = Hit;
      hit = (a[31:4] == BASE[31:4]);
      chk("hit", {31'b0, hit_obs}, {31'b0, hit});
      chk("readdata", rd_obs, model_read(a));
      wr_out  = mw && hit && a[3:2] == 2'd0;
      wr_stat = mw && hit && a[3:2] == 2'd2;
      wr_tmr  = mw && hit && a[3:2] == 2'd3;
      rd_in   = mr && hit && a[3:2] == 2'd1;
      chg     = hist[S-1] != hist[S];
      if (rst) begin
         m_out = '0; m_valid = 0; m_inchg = 0; m_ovr = 0; m_timer = '0;
         for (int i = 0; i <= S; i++) hist[i] = '0;
      end else begin
         if (wr_out && m_valid && !ack) m_ovr = 1;
         else if (!wr_out && wr_stat && wd[2]) m_ovr = 0;
         if (chg) m_inchg = 1;
         else if (rd_in || (wr_stat && wd[0])) m_inchg = 0;
         if (wr_out) begin m_out = wd; m_valid = 1; end
         else if (ack) m_valid = 0;
         m_timer = wr_tmr ? wd : m_timer + 32'd1;
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = pin_v;
      end
      @(posedge clk);
      #1;
      chk("portout", PortOut, m_out);
      chk("outvalid", {31'b0, OutValid}, {31'b0, m_valid});
   endtask

   logic [31:0] ra;

   initial begin
      m_out = '0; m_valid = 0; m_inchg = 0; m_ovr = 0; m_timer = '0;
      for (int i = 0; i <= S; i++) hist[i] = '0;

      step(1, 32'h0, 0, 0, 0, 0);
      step(1, 32'h0, 0, 0, 0, 0);
      chk("reset_portout", PortOut, 32'h0);
      chk("reset_outvalid", {31'b0, OutValid}, 32'h0);

      // Store, status, acknowledge
      step(0, BASE, 32'hDEAD_BEEF, 1, 0, 0);
      chk("store_portout", PortOut, 32'hDEAD_BEEF);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("status_pending", rd_obs, 32'h2);
      step(0, 32'h0, 0, 0, 0, 1);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("status_acked", rd_obs, 32'h0);

      // Overrun and its W1C
      step(0, BASE, 32'h11, 1, 0, 0);
      step(0, BASE, 32'h22, 1, 0, 0);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("status_overrun", rd_obs, 32'h6);
      chk("overrun_portout", PortOut, 32'h22);
      step(0, BASE + 8, 32'h4, 1, 0, 0);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("status_w1c", rd_obs, 32'h2);

      // Store coinciding with acknowledge
      step(0, BASE, 32'h33, 1, 0, 1);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("store_ack_status", rd_obs, 32'h2);
      chk("store_ack_portout", PortOut, 32'h33);
      step(0, 32'h0, 0, 0, 0, 1);

      // Input synchronizer and change detection
      pin_v = 8'hA5;
      step(0, 32'h0, 0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0, 0);
      step(0, BASE + 4, 0, 0, 0, 0);
      chk("portin_sync", rd_obs, 32'hA5);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("in_changed_set", rd_obs, 32'h1);
      step(0, BASE + 4, 0, 0, 1, 0);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("in_changed_clr", rd_obs, 32'h0);
      pin_v = 8'h5A;
      step(0, 32'h0, 0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0, 0);
      step(0, BASE + 4, 0, 0, 1, 0);
      step(0, BASE + 8, 0, 0, 1, 0);
      chk("in_changed_setwins", rd_obs, 32'h1);

      // Outside the window
      step(0, BASE + 32'h10, 32'h99, 1, 1, 0);
      chk("miss_hi_hit", {31'b0, hit_obs}, 32'h0);
      chk("miss_hi_rd", rd_obs, 32'h0);
      step(0, 32'h1000_0000, 32'h77, 1, 1, 0);
      chk("miss_lo_rd", rd_obs, 32'h0);
      chk("miss_portout", PortOut, 32'h33);
      step(0, BASE + 3, 0, 0, 1, 0);
      chk("low_bits_ignored", rd_obs, 32'h33);

      // Timer register
      step(0, BASE + 12, 32'hFFFF_FFFE, 1, 0, 0);
      step(0, BASE + 12, 0, 0, 1, 0);
`ifdef MMIO_PORT_TIMER_EN
      chk("timer_load", rd_obs, 32'hFFFF_FFFE);
      step(0, BASE + 12, 0, 0, 1, 0);
      chk("timer_max", rd_obs, 32'hFFFF_FFFF);
      step(0, BASE + 12, 0, 0, 1, 0);
      chk("timer_wrap", rd_obs, 32'h0);
      step(1, BASE + 12, 0, 0, 1, 0);
      step(0, BASE + 12, 0, 0, 1, 0);
      chk("timer_reset", rd_obs, 32'h0);
`else
      chk("timer_absent", rd_obs, 32'h0);
      step(0, BASE + 12, 0, 0, 1, 0);
      chk("timer_absent2", rd_obs, 32'h0);
`endif

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2, 3: ra = BASE + {28'b0, 4'($urandom)};
            4:          ra = BASE + 32'h10 + {28'b0, 4'($urandom)};
            default:    ra = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) pin_v = 8'($urandom);
         step(($urandom_range(0, 60) == 0), ra, $urandom, 1'($urandom), 1'($urandom),
              1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
